// File: rtl/mic1_uart_mmio.sv
// mic1_uart_mmio: memory-mapped UART bridge for the mic1 data bus.
// Adds RX/TX FIFOs, a status/control register, a sticky RX overrun flag
// and a drain state machine that feeds uart_tx one byte at a time.
module mic1_uart_mmio #(
    parameter logic [31:0] DATA_ADDR   = 32'hFFFF_FFFD,
    parameter logic [31:0] STATUS_ADDR = 32'hFFFF_FFFC,
    parameter int          RX_DEPTH    = 8,
    parameter int          TX_DEPTH    = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        bus_en,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        io_sel,
    output logic [31:0] io_rdata,
    output logic        stall,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        rx_overrun
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_AW + 1;
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);
    localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } tx_state_t;

    // Status count fields are 8 bits; deeper FIFOs report 255 when fuller.
    function automatic logic [7:0] sat8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

    logic [7:0]       r_rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] r_rx_wptr;
    logic [RX_AW-1:0] r_rx_rptr;
    logic [RX_CW-1:0] r_rx_cnt;
    logic [7:0]       r_tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] r_tx_wptr;
    logic [TX_AW-1:0] r_tx_rptr;
    logic [TX_CW-1:0] r_tx_cnt;
    tx_state_t        r_state;
    logic             r_tx_start;
    logic [7:0]       r_tx_data;
    logic             r_rx_overrun;

    logic        w_rd, w_wr, w_data_sel, w_stat_sel;
    logic        w_rx_empty, w_rx_full, w_rx_pop, w_rx_push, w_ovr_set, w_ovr_clr;
    logic        w_tx_empty, w_tx_full, w_tx_push, w_tx_pop, w_line_idle;
    logic [31:0] w_status;
    logic        w_unused;

    assign w_rd       = bus_en & mem_read;
    assign w_wr       = bus_en & mem_write;
    assign w_data_sel = (mem_addr == DATA_ADDR);
    assign w_stat_sel = (mem_addr == STATUS_ADDR);

    assign w_rx_empty = (r_rx_cnt == {RX_CW{1'b0}});
    assign w_rx_full  = (r_rx_cnt == RX_FULL_CNT);
    assign w_rx_pop   = w_rd & w_data_sel & ~w_rx_empty;
    // A pop in the same cycle makes room, so a push into a full FIFO still lands.
    assign w_rx_push  = rx_done & (~w_rx_full | w_rx_pop);
    assign w_ovr_set  = rx_done & w_rx_full & ~w_rx_pop;
    assign w_ovr_clr  = w_wr & w_stat_sel & mem_wdata[3];

    assign w_tx_empty  = (r_tx_cnt == {TX_CW{1'b0}});
    assign w_tx_full   = (r_tx_cnt == TX_FULL_CNT);
    // Fullness is judged before the LOAD pop; a full FIFO stalls even then.
    assign w_tx_push   = w_wr & w_data_sel & ~w_tx_full;
    assign w_tx_pop    = (r_state == ST_LOAD);
    assign w_line_idle = w_tx_empty & (r_state == ST_IDLE);

    assign w_status = {8'h00, sat8(32'(r_tx_cnt)), sat8(32'(r_rx_cnt)),
                       4'h0, r_rx_overrun, w_line_idle, w_tx_full, ~w_rx_empty};
    assign w_unused = &{1'b0, mem_wdata[31:8]};

    assign io_sel     = w_data_sel | w_stat_sel;
    assign stall      = w_wr & w_data_sel & w_tx_full;
    assign tx_start   = r_tx_start;
    assign tx_data    = r_tx_data;
    assign rx_overrun = r_rx_overrun;

    // Read-data mux for the two I/O registers.
    always_comb begin
        io_rdata = 32'h0000_0000;
        if (w_data_sel) begin
            if (w_rx_empty) begin
                io_rdata = 32'h0000_0000;
            end else begin
                io_rdata = {24'h00_0000, r_rx_mem[r_rx_rptr]};
            end
        end else if (w_stat_sel) begin
            io_rdata = w_status;
        end else begin
            io_rdata = 32'h0000_0000;
        end
    end

    // RX FIFO storage, pointers, occupancy and sticky overrun flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < RX_DEPTH; i++) r_rx_mem[i] <= 8'h00;
            r_rx_wptr    <= {RX_AW{1'b0}};
            r_rx_rptr    <= {RX_AW{1'b0}};
            r_rx_cnt     <= {RX_CW{1'b0}};
            r_rx_overrun <= 1'b0;
        end else begin
            if (w_rx_push) begin
                r_rx_mem[r_rx_wptr] <= rx_data;
                r_rx_wptr           <= r_rx_wptr + 1'b1;
            end
            if (w_rx_pop) begin
                r_rx_rptr <= r_rx_rptr + 1'b1;
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
                2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
            // Setting wins over a simultaneous clear so no overrun is lost.
            if (w_ovr_set) begin
                r_rx_overrun <= 1'b1;
            end else if (w_ovr_clr) begin
                r_rx_overrun <= 1'b0;
            end else begin
                r_rx_overrun <= r_rx_overrun;
            end
        end
    end

    // TX FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < TX_DEPTH; i++) r_tx_mem[i] <= 8'h00;
            r_tx_wptr <= {TX_AW{1'b0}};
            r_tx_rptr <= {TX_AW{1'b0}};
            r_tx_cnt  <= {TX_CW{1'b0}};
        end else begin
            if (w_tx_push) begin
                r_tx_mem[r_tx_wptr] <= mem_wdata[7:0];
                r_tx_wptr           <= r_tx_wptr + 1'b1;
            end
            if (w_tx_pop) begin
                r_tx_rptr <= r_tx_rptr + 1'b1;
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
                2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // TX drain FSM: present head with a one-cycle start, then follow tx_busy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_tx_empty && !tx_busy) begin
                        r_tx_data  <= r_tx_mem[r_tx_rptr];
                        r_tx_start <= 1'b1;
                        r_state    <= ST_LOAD;
                    end else begin
                        r_tx_start <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    r_tx_start <= 1'b0;
                    r_state    <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    r_tx_start <= 1'b0;
                    if (tx_busy) begin
                        r_state <= ST_WAIT_LO;
                    end else begin
                        r_state <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_LO: begin
                    r_tx_start <= 1'b0;
                    if (!tx_busy) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT_LO;
                    end
                end
                default: begin
                    r_tx_start <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
